// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues req/ack fetches at PC, queues returned
// words for decode, and handles redirects by flushing and squashing in-flight data.
module fetch_unit #(
    parameter int WIDTH = 16,
    parameter int INC   = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] next_pc,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             instr_valid,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    input  logic             instr_ready
);
    // state | meaning
    // IDLE  | no request outstanding; issue at PC when the queue has space
    // WAIT  | request outstanding; imem_addr held until imem_ack
    typedef enum logic {IDLE, WAIT} state_t;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
    localparam logic [WIDTH-1:0] INC_W   = WIDTH'(INC);

    state_t           state, state_nx;
    logic [CW-1:0]    count, count_nx;
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [WIDTH-1:0] mem_instr [DEPTH];
    logic [WIDTH-1:0] mem_pc    [DEPTH];
    logic             squash, squash_nx;
    logic             req_nx;
    logic [WIDTH-1:0] addr_nx;
    logic             accept, push, pop;

    assign accept      = imem_req & imem_ack & ~squash;
    assign push        = accept & ~redirect;
    assign pop         = instr_valid & instr_ready;
    assign instr_valid = (count != '0);
    assign instr       = mem_instr[rd_ptr];
    assign instr_pc    = mem_pc[rd_ptr];

    always_comb begin
        next_pc = PC;
        if (reset)
            next_pc = '0;
        else if (redirect)
            next_pc = redirect_pc;
        else if (accept)
            next_pc = PC + INC_W;
    end

    // Flush wins over a simultaneous pop.
    always_comb begin
        count_nx = count;
        if (redirect)
            count_nx = '0;
        else if (push && !pop)
            count_nx = count + CW'(1);
        else if (!push && pop)
            count_nx = count - CW'(1);
    end

    always_comb begin
        state_nx  = state;
        req_nx    = imem_req;
        addr_nx   = imem_addr;
        squash_nx = squash;
        case (state)
            IDLE: begin
                if (!redirect && (count < DEPTH_C)) begin
                    req_nx   = 1'b1;
                    addr_nx  = PC;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    squash_nx = 1'b0;
                    // After a squashed ack next_pc equals PC, i.e. the redirect target.
                    if (!redirect && (count_nx < DEPTH_C)) begin
                        addr_nx = next_pc;
                    end else begin
                        req_nx   = 1'b0;
                        state_nx = IDLE;
                    end
                end else if (redirect) begin
                    squash_nx = 1'b1;
                end
            end
            default: begin
                req_nx   = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            squash    <= 1'b0;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr[i] <= '0;
                mem_pc[i]    <= '0;
            end
        end else begin
            state     <= state_nx;
            imem_req  <= req_nx;
            imem_addr <= addr_nx;
            squash    <= squash_nx;
            count     <= count_nx;
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    mem_instr[wr_ptr] <= imem_rdata;
                    mem_pc[wr_ptr]    <= imem_addr;
                    wr_ptr            <= wr_ptr + AW'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle table from reset, directed corner sequences,
// then random traffic checked against a queue-level scoreboard.
module tb_fetch_unit;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pc_reg;
    logic [15:0] next_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready = 1'b0;

    int n_err = 0;
    int n_checks = 0;

    fetch_unit #(.WIDTH(16), .INC(4), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .PC(pc_reg), .next_pc(next_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    // program_counter register and a memory whose word is 0x1000 + address
    always @(posedge clk or posedge reset)
        if (reset) pc_reg <= '0;
        else       pc_reg <= next_pc;
    assign imem_rdata = imem_addr + 16'h1000;

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic a, input logic r, input logic rd, input logic [15:0] rp);
        imem_ack = a; instr_ready = r; redirect = rd; redirect_pc = rp;
        #1;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 16'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic        ack, ready;
        logic [15:0] npc;
        logic        req;
        logic [15:0] addr;
        logic        valid;
        logic [15:0] ins, ipc;
    } vec_t;
    vec_t tbl[10];

    typedef struct { logic [15:0] ins, pc; } ent_t;
    ent_t mq[$];

    initial begin
        logic a, r, rd, acc, prev_req, prev_ack, prev_idle_space, prev_full_idle, stale;
        logic [15:0] rp, exp_pc, enpc, prev_addr;

        // first fetch, backpressure to full, release and resume at 0x0008
        tbl[0] = '{0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000};
        tbl[1] = '{1, 0, 16'h0004, 1, 16'h0000, 0, 16'h0000, 16'h0000};
        tbl[2] = '{1, 0, 16'h0008, 1, 16'h0004, 1, 16'h1000, 16'h0000};
        tbl[3] = '{0, 0, 16'h0008, 0, 16'h0004, 1, 16'h1000, 16'h0000};
        tbl[4] = '{0, 0, 16'h0008, 0, 16'h0004, 1, 16'h1000, 16'h0000};
        tbl[5] = '{0, 1, 16'h0008, 0, 16'h0004, 1, 16'h1000, 16'h0000};
        tbl[6] = '{0, 0, 16'h0008, 0, 16'h0004, 1, 16'h1004, 16'h0004};
        tbl[7] = '{1, 1, 16'h000C, 1, 16'h0008, 1, 16'h1004, 16'h0004};
        tbl[8] = '{0, 1, 16'h000C, 1, 16'h000C, 1, 16'h1008, 16'h0008};
        tbl[9] = '{0, 0, 16'h000C, 1, 16'h000C, 0, 16'h0000, 16'h0000};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].ack, tbl[i].ready, 0, 16'h0);
            chk($sformatf("t%0d_next_pc", i), next_pc, tbl[i].npc);
            chk($sformatf("t%0d_req", i), imem_req, tbl[i].req);
            chk($sformatf("t%0d_addr", i), imem_addr, tbl[i].addr);
            chk($sformatf("t%0d_valid", i), instr_valid, tbl[i].valid);
            if (tbl[i].valid || i == 0) begin
                chk($sformatf("t%0d_instr", i), instr, tbl[i].ins);
                chk($sformatf("t%0d_instr_pc", i), instr_pc, tbl[i].ipc);
            end
            step();
        end

        // redirect while the fetch at 0x0008 waits three cycles for its ack
        do_reset();
        drive(0, 1, 0, 16'h0);      chk("rd_c0_req", imem_req, 0); step();
        drive(1, 1, 0, 16'h0);      chk("rd_c1_addr", imem_addr, 16'h0000); step();
        drive(1, 1, 0, 16'h0);      chk("rd_c2_addr", imem_addr, 16'h0004); step();
        drive(0, 1, 0, 16'h0);      chk("rd_c3_addr", imem_addr, 16'h0008); step();
        drive(0, 1, 1, 16'h0040);   chk("rd_c4_addr", imem_addr, 16'h0008);
                                    chk("rd_c4_next_pc", next_pc, 16'h0040); step();
        drive(0, 1, 0, 16'h0);      chk("rd_c5_addr", imem_addr, 16'h0008);
                                    chk("rd_c5_req", imem_req, 1);
                                    chk("rd_c5_valid", instr_valid, 0); step();
        drive(1, 1, 0, 16'h0);      chk("rd_c6_addr", imem_addr, 16'h0008);
                                    chk("rd_c6_next_pc", next_pc, 16'h0040); step();
        drive(1, 1, 0, 16'h0);      chk("rd_c7_valid", instr_valid, 0);
                                    chk("rd_c7_req", imem_req, 1);
                                    chk("rd_c7_addr", imem_addr, 16'h0040); step();
        drive(0, 1, 0, 16'h0);      chk("rd_c8_valid", instr_valid, 1);
                                    chk("rd_c8_instr", instr, 16'h1040);
                                    chk("rd_c8_instr_pc", instr_pc, 16'h0040); step();

        // redirect, ack and pop together
        do_reset();
        drive(0, 0, 0, 16'h0);      step();
        drive(1, 0, 0, 16'h0);      chk("sim_c1_addr", imem_addr, 16'h0000); step();
        drive(1, 1, 1, 16'h0080);   chk("sim_c2_valid", instr_valid, 1);
                                    chk("sim_c2_addr", imem_addr, 16'h0004);
                                    chk("sim_c2_next_pc", next_pc, 16'h0080); step();
        drive(0, 0, 0, 16'h0);      chk("sim_c3_valid", instr_valid, 0);
                                    chk("sim_c3_req", imem_req, 0); step();
        drive(1, 1, 0, 16'h0);      chk("sim_c4_req", imem_req, 1);
                                    chk("sim_c4_addr", imem_addr, 16'h0080); step();
        drive(0, 1, 0, 16'h0);      chk("sim_c5_valid", instr_valid, 1);
                                    chk("sim_c5_instr", instr, 16'h1080);
                                    chk("sim_c5_instr_pc", instr_pc, 16'h0080); step();

        // wrap-around from 0xFFFC
        do_reset();
        drive(0, 0, 1, 16'hFFFC);   chk("wr_c0_next_pc", next_pc, 16'hFFFC); step();
        drive(0, 0, 0, 16'h0);      chk("wr_c1_req", imem_req, 0); step();
        drive(1, 1, 0, 16'h0);      chk("wr_c2_addr", imem_addr, 16'hFFFC);
                                    chk("wr_c2_next_pc", next_pc, 16'h0000); step();
        drive(0, 1, 0, 16'h0);      chk("wr_c3_addr", imem_addr, 16'h0000);
                                    chk("wr_c3_instr", instr, 16'h0FFC);
                                    chk("wr_c3_instr_pc", instr_pc, 16'hFFFC); step();

        // asynchronous reset between edges, request pending and one entry queued
        do_reset();
        drive(0, 0, 0, 16'h0);      step();
        drive(1, 0, 0, 16'h0);      step();
        drive(0, 0, 0, 16'h0);      chk("ar_pre_req", imem_req, 1);
                                    chk("ar_pre_valid", instr_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("ar_req", imem_req, 0);
        chk("ar_valid", instr_valid, 0);
        chk("ar_next_pc", next_pc, 16'h0000);
        step();

        // random traffic against a queue scoreboard
        do_reset();
        mq.delete();
        exp_pc = '0; stale = 0;
        prev_req = 0; prev_ack = 0; prev_addr = '0;
        prev_idle_space = 0; prev_full_idle = 0;
        for (int k = 0; k < 3000; k++) begin
            a  = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 2) != 0);
            rd = ($urandom_range(0, 15) == 0);
            rp = 16'($urandom) & 16'hFFFC;
            drive(a, r, rd, rp);

            chk("r_valid", instr_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("r_instr", instr, mq[0].ins);
                chk("r_instr_pc", instr_pc, mq[0].pc);
            end
            if (prev_req && !prev_ack) begin
                chk("r_hold_req", imem_req, 1);
                chk("r_hold_addr", imem_addr, prev_addr);
            end
            if (prev_idle_space) chk("r_issue", imem_req, 1);
            if (prev_full_idle)  chk("r_no_issue", imem_req, 0);
            acc = imem_req && a && !stale;
            if (acc && !rd) chk("r_fetch_addr", imem_addr, exp_pc);
            enpc = rd ? rp : (acc ? exp_pc + 16'd4 : exp_pc);
            chk("r_next_pc", next_pc, enpc);

            prev_req = imem_req; prev_ack = a; prev_addr = imem_addr;
            prev_idle_space = !imem_req && (mq.size() < DEPTH) && !rd;
            prev_full_idle  = !imem_req && (mq.size() == DEPTH);

            if (rd) begin
                mq.delete();
                stale  = imem_req && !a;
                exp_pc = rp;
            end else begin
                if (mq.size() != 0 && r) void'(mq.pop_front());
                if (imem_req && a) begin
                    if (stale) stale = 0;
                    else begin
                        chk("r_overflow", mq.size() < DEPTH, 1);
                        mq.push_back('{exp_pc + 16'h1000, exp_pc});
                        exp_pc = exp_pc + 16'd4;
                    end
                end
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
